// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; building block for the serial bit cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_bit_cell.sv
// Combinational one-bit full adder made of two half adders and an OR of their carries.
module serial_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: LSB-first, one bit per clock through a shared full-adder cell.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_s;
  logic             bit_co;

  serial_bit_cell u_cell (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (bit_s),
    .co (bit_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // After WIDTH shifts the sum register holds only freshly computed bits.
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = bit_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = bit_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus hand-written corner sequences.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         done_valid;
  logic         done_ready;
  logic         busy;
  state_t       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sum         (sum),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands in IDLE; after acceptance either drop start_valid or
  // keep it high with different operands that must be ignored.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    start_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    if (hold) begin
      a = 8'h11;
      b = 8'h22;
    end else begin
      start_valid = 1'b0;
    end
  endtask

  // Count edges after acceptance until done_valid, then check the result.
  task automatic wait_done(input logic [W-1:0] exp_sum, input logic exp_cout);
    int n;
    n = 0;
    while (!done_valid && n < 20) begin
      check("start_ready_busy", start_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    if (!done_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done_valid after %0d edges, expected %0d", n, W);
    end else begin
      check("latency", n, W);
    end
    start_valid = 1'b0;
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
    check("busy_done", busy, 1);
    check("start_ready_done", start_ready, 0);
  endtask

  // Optionally stall done_ready, then complete the output handshake.
  task automatic finish_op(input int stall, input logic [W-1:0] exp_sum, input logic exp_cout);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_done_valid", done_valid, 1);
      check("stall_sum", sum, exp_sum);
      check("stall_cout", cout, exp_cout);
    end
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    check("done_valid_after", done_valid, 0);
    check("start_ready_after", start_ready, 1);
    check("busy_after", busy, 0);
    check("sum_hold", sum, exp_sum);
    check("cout_hold", cout, exp_cout);
  endtask

  task automatic check_reset_outputs();
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start_ready", start_ready, 1);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[4] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 8'h7F, 8'h80, 1'b0};

    rst         = 1'b1;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();

    // table-driven basic operations
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].va, vecs[i].vb, 1'b0);
      wait_done(vecs[i].exp_sum, vecs[i].exp_cout);
      finish_op(0, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // start_valid held through RUN with new operands: ignored
    start_op(8'h5A, 8'h33, 1'b1);
    wait_done(8'h8D, 1'b0);
    finish_op(0, 8'h8D, 1'b0);

    // consumer stalls for 5 cycles in DONE
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(8'hFE, 1'b1);
    finish_op(5, 8'hFE, 1'b1);

    // done_ready outside DONE is ignored
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_done_ready", done_valid, 0);
    done_ready = 1'b0;

    // asynchronous reset in RUN cycle 3 aborts the operation
    start_op(8'h5A, 8'h33, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done(8'h10, 1'b0);
    finish_op(0, 8'h10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
